// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared constants and the queue entry type for the fetch stage.
package instruction_fetch_pkg;
    localparam logic [31:0] NOP_INST  = 32'h4020_0000;
    localparam logic [31:0] LNOP_INST = 32'h0020_0000;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst0;
        logic [31:0] inst1;
    } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: decode-side and local-store-side signals of the fetch stage.
// Big-endian bit 0 of each bus is its MSB, so word [0:31] of a pair sits in [63:32].
interface instruction_fetch_if #(parameter int LS_ADDR_W = 15);
    logic                 stall;
    logic                 branch_taken;
    logic                 flush;
    logic [31:0]          branch_target;
    logic                 imem_req;
    logic [LS_ADDR_W-1:0] imem_addr;
    logic [63:0]          imem_rdata;
    logic [31:0]          first_inst_output;
    logic [31:0]          second_inst_output;
    logic                 inst_valid;
    logic [31:0]          pc_output;
    modport master (
        input  stall, branch_taken, flush, branch_target, imem_rdata,
        output imem_req, imem_addr, first_inst_output, second_inst_output, inst_valid, pc_output
    );
    modport slave (
        output stall, branch_taken, flush, branch_target, imem_rdata,
        input  imem_req, imem_addr, first_inst_output, second_inst_output, inst_valid, pc_output
    );
endinterface

// File: rtl/instruction_fetch_buffer.sv
// fetch_buffer: instruction-pair FIFO; the count tells full from empty, clear beats push and pop.
module fetch_buffer
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             din,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_pop;
    assign do_pop = pop && count != '0;
    assign head = mem[rd_ptr];
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, push};
            rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, do_pop};
            count  <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
        end
    end
    always_ff @(posedge clock) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: issues aligned pair fetches to local store, queues returns, feeds decode.
// Redirects clear the queue and suppress the in-flight return; a mid-pair target blanks slot 0.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int          IBUF_DEPTH = 4,
    parameter int          LS_ADDR_W  = 15,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clock,
    input logic reset,
    instruction_fetch_if.master bus
);
    localparam int CW = $clog2(IBUF_DEPTH) + 1;
    logic [31:0] fetch_pc, ret_pc, pc_last;
    logic running, inflight, mid_pair, redirect, issue, pop;
    logic [CW-1:0] count;
    fetch_entry_t head, entry;
    assign redirect = bus.branch_taken | bus.flush;
    // credit check counts the pending return so a push never lands on a full queue
    assign issue = running && !redirect && (count + CW'(inflight)) < CW'(IBUF_DEPTH);
    assign pop = bus.inst_valid && !bus.stall;
    assign entry = '{pc: ret_pc,
                     inst0: mid_pair ? NOP_INST : bus.imem_rdata[63:32],
                     inst1: bus.imem_rdata[31:0]};
    assign bus.imem_req = issue;
    assign bus.imem_addr = {fetch_pc[LS_ADDR_W-1:3], 3'b000};
    assign bus.inst_valid = count != '0;
    assign bus.first_inst_output = bus.inst_valid ? head.inst0 : NOP_INST;
    assign bus.second_inst_output = bus.inst_valid ? head.inst1 : NOP_INST;
    assign bus.pc_output = bus.inst_valid ? head.pc : pc_last;
    fetch_buffer #(.DEPTH(IBUF_DEPTH)) u_buf (
        .clock(clock),
        .reset(reset),
        .push(inflight),
        .pop(pop),
        .clear(redirect),
        .din(entry),
        .count(count),
        .head(head)
    );
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            running  <= 1'b0;
            inflight <= 1'b0;
            mid_pair <= 1'b0;
            fetch_pc <= RESET_PC;
            ret_pc   <= '0;
            pc_last  <= '0;
        end else begin
            running  <= 1'b1;
            inflight <= issue;
            if (bus.inst_valid) pc_last <= head.pc;
            if (redirect) begin
                fetch_pc <= bus.branch_target & 32'hFFFF_FFF8;
                mid_pair <= bus.branch_target[2];
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 32'd8;
                    ret_pc   <= fetch_pc;
                end
                if (inflight) mid_pair <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of fetch issue, queueing, stall, redirect, wrap and reset.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int compared = 0;
    int mismatched = 0;
    instruction_fetch_if #(.LS_ADDR_W(15)) bus();
    instruction_fetch #(.IBUF_DEPTH(4), .LS_ADDR_W(15), .RESET_PC(32'h0000_0000)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.master)
    );
    always #5 clock = ~clock;
    function automatic logic [31:0] w_hi(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction
    function automatic logic [31:0] w_lo(input logic [31:0] a);
        return 32'hB000_0000 | (a + 32'd4);
    endfunction
    // local store: pair at byte address a is {w_hi(a), w_lo(a)}, one cycle after the request
    always @(posedge clock)
        bus.imem_rdata <= bus.imem_req ? {w_hi(32'(bus.imem_addr)), w_lo(32'(bus.imem_addr))}
                                       : 64'hDEAD_DEAD_DEAD_DEAD;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask
    task automatic chk_pair(input string tag, input logic [31:0] pc, input logic [31:0] i0);
        chk({tag, "_valid"}, bus.inst_valid, 1);
        chk({tag, "_pc"}, bus.pc_output, pc);
        chk({tag, "_first"}, bus.first_inst_output, i0);
        chk({tag, "_second"}, bus.second_inst_output, w_lo(pc & 32'h7FFF));
    endtask
    initial begin
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.flush = 1'b0;
        bus.branch_target = '0;
        cyc(2);
        chk("rst_valid", bus.inst_valid, 0);
        chk("rst_req", bus.imem_req, 0);
        chk("rst_first", bus.first_inst_output, NOP_INST);
        chk("rst_second", bus.second_inst_output, NOP_INST);
        chk("rst_pc", bus.pc_output, 0);
        reset = 1'b1;
        #1;
        chk("pre_edge_req", bus.imem_req, 0);
        cyc(1);
        chk("first_req", bus.imem_req, 1);
        chk("first_addr", bus.imem_addr, 15'h0000);
        cyc(1);
        chk("lat_valid", bus.inst_valid, 0);
        chk("second_addr", bus.imem_addr, 15'h0008);
        cyc(1);
        for (int k = 0; k < 6; k++) begin
            chk_pair("stream", 32'(8 * k), w_hi(32'(8 * k)));
            cyc(1);
        end
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h0000_0100;
        #1;
        chk("redir_req", bus.imem_req, 0);
        cyc(1);
        bus.branch_taken = 1'b0;
        #1;
        chk("redir_cleared", bus.inst_valid, 0);
        chk("redir_req_next", bus.imem_req, 1);
        chk("redir_addr", bus.imem_addr, 15'h0100);
        cyc(1);
        chk("redir_gap", bus.inst_valid, 0);
        cyc(1);
        chk_pair("redir_first", 32'h100, w_hi(32'h100));
        cyc(1);
        chk_pair("redir_next", 32'h108, w_hi(32'h108));
        bus.flush = 1'b1;
        bus.branch_target = 32'h0000_0204;
        #1;
        chk("flush_req", bus.imem_req, 0);
        cyc(1);
        bus.flush = 1'b0;
        cyc(2);
        chk_pair("mid_pair", 32'h200, NOP_INST);
        cyc(1);
        chk_pair("mid_after", 32'h208, w_hi(32'h208));
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h0000_7FF8;
        cyc(1);
        bus.branch_taken = 1'b0;
        #1;
        chk("wrap_addr0", bus.imem_addr, 15'h7FF8);
        cyc(1);
        chk("wrap_req1", bus.imem_req, 1);
        chk("wrap_addr1", bus.imem_addr, 15'h0000);
        cyc(1);
        chk_pair("wrap_top", 32'h7FF8, w_hi(32'h7FF8));
        cyc(1);
        chk_pair("wrap_over", 32'h8000, w_hi(32'h0));
        reset = 1'b0;
        bus.stall = 1'b1;
        #1;
        chk("async_rst_valid", bus.inst_valid, 0);
        chk("async_rst_req", bus.imem_req, 0);
        cyc(1);
        reset = 1'b1;
        cyc(5);
        chk("fill3_valid", bus.inst_valid, 1);
        chk("fill3_pc", bus.pc_output, 0);
        chk("fill3_req", bus.imem_req, 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", bus.inst_valid, 0);
        chk("mid_rst_req", bus.imem_req, 0);
        chk("mid_rst_first", bus.first_inst_output, NOP_INST);
        chk("mid_rst_pc", bus.pc_output, 0);
        cyc(1);
        reset = 1'b1;
        cyc(10);
        chk("stall_req", bus.imem_req, 0);
        bus.stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_pair("drain", 32'(8 * k), w_hi(32'(8 * k)));
            cyc(1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
